// File: rtl/mhc_pkg.sv
// Shared types and default dimensions for the minute/hour cascade.
package mhc_pkg;

  localparam int unsigned DefMinMod  = 60;
  localparam int unsigned DefHourMod = 24;
  localparam int unsigned DefMinW    = 6;
  localparam int unsigned DefHourW   = 5;

  typedef enum logic [1:0] {
    StRun,
    StCheck,
    StApply
  } state_e;

endpackage

// File: rtl/wrap_inc.sv
// Combinational modulo incrementer: value+1 wrapping to 0 at MOD, with a wrap flag.
module wrap_inc #(
  parameter int unsigned MOD = 60,
  parameter int unsigned W   = 6
) (
  input  logic [W-1:0] value_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  always_comb begin
    value_o = value_i;
    wrap_o  = 1'b0;
    if (inc_i) begin
      // Compare in 32 bits so MOD == 2**W does not truncate to zero.
      if (32'(value_i) >= MOD - 1) begin
        value_o = '0;
        wrap_o  = 1'b1;
      end else begin
        value_o = value_i + W'(1);
      end
    end
  end

endmodule

// File: rtl/minute_hour_cascade.sv
// Minutes/hours time-of-day counter driven by per-minute ticks, with a checked set path.
// Optional alarm comparator enabled by defining ALARM_EN.
module minute_hour_cascade
  import mhc_pkg::*;
#(
  parameter int unsigned MIN_MOD  = DefMinMod,
  parameter int unsigned HOUR_MOD = DefHourMod,
  parameter int unsigned MIN_W    = DefMinW,
  parameter int unsigned HOUR_W   = DefHourW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              min_tick,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              hour_done,
  output logic              day_done,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HOUR_W-1:0] set_hour,
  output logic              set_err,
  output logic              tick_overrun
`ifdef ALARM_EN
  ,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic              alarm_arm,
  output logic              alarm
`endif
);

  state_e              state_q, state_d;
  logic [MIN_W-1:0]    min_q, min_d;
  logic [HOUR_W-1:0]   hour_q, hour_d;
  logic [MIN_W-1:0]    stg_min_q, stg_min_d;
  logic [HOUR_W-1:0]   stg_hour_q, stg_hour_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                set_ready_q, set_ready_d;
  logic                set_err_q, set_err_d;
  logic                hour_done_q, hour_done_d;
  logic                day_done_q, day_done_d;

  logic                accept;
  logic                tick_inc;
  logic [MIN_W-1:0]    min_next;
  logic [HOUR_W-1:0]   hour_next;
  logic                min_wrap;
  logic                hour_wrap;

  assign accept   = set_valid && set_ready_q && (state_q == StRun);
  // A tick coincident with an accepted set is deferred into pending instead.
  assign tick_inc = (state_q == StRun) && !accept && (min_tick || pending_q);

  wrap_inc #(
    .MOD (MIN_MOD),
    .W   (MIN_W)
  ) u_min_inc (
    .value_i (min_q),
    .inc_i   (tick_inc),
    .value_o (min_next),
    .wrap_o  (min_wrap)
  );

  wrap_inc #(
    .MOD (HOUR_MOD),
    .W   (HOUR_W)
  ) u_hour_inc (
    .value_i (hour_q),
    .inc_i   (min_wrap),
    .value_o (hour_next),
    .wrap_o  (hour_wrap)
  );

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    hour_d      = hour_q;
    stg_min_d   = stg_min_q;
    stg_hour_d  = stg_hour_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    set_err_d   = 1'b0;
    hour_done_d = tick_inc && min_wrap;
    day_done_d  = tick_inc && min_wrap && hour_wrap;

    // Ticks outside RUN, or on an accept cycle, can only be deferred.
    if ((state_q != StRun || accept) && min_tick) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      StRun: begin
        if (accept) begin
          stg_min_d  = set_min;
          stg_hour_d = set_hour;
          state_d    = StCheck;
        end else if (tick_inc) begin
          min_d     = min_next;
          hour_d    = hour_next;
          // Pending and a fresh tick together: apply one, keep the other queued.
          pending_d = min_tick && pending_q;
        end
      end
      StCheck: begin
        if (32'(stg_min_q) >= MIN_MOD || 32'(stg_hour_q) >= HOUR_MOD) begin
          set_err_d = 1'b1;
          state_d   = StRun;
        end else begin
          state_d = StApply;
        end
      end
      StApply: begin
        min_d   = stg_min_q;
        hour_d  = stg_hour_q;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    set_ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      min_q       <= '0;
      hour_q      <= '0;
      stg_min_q   <= '0;
      stg_hour_q  <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      hour_done_q <= 1'b0;
      day_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      stg_min_q   <= stg_min_d;
      stg_hour_q  <= stg_hour_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      hour_done_q <= hour_done_d;
      day_done_q  <= day_done_d;
    end
  end

`ifdef ALARM_EN
  logic alarm_q, alarm_d;

  // Only tick-driven increments can fire; set writes bypass this path.
  always_comb begin
    alarm_d = alarm_arm && tick_inc && (min_next == alarm_min) && (hour_next == alarm_hour);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

  assign minutes      = min_q;
  assign hours        = hour_q;
  assign hour_done    = hour_done_q;
  assign day_done     = day_done_q;
  assign set_ready    = set_ready_q;
  assign set_err      = set_err_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_minute_hour_cascade.sv
// Directed self-checking bench for minute_hour_cascade; alarm checks compile in with ALARM_EN.
module tb_minute_hour_cascade;

  logic       clk = 1'b0;
  logic       rst;
  logic       min_tick;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       hour_done;
  logic       day_done;
  logic       set_valid;
  logic       set_ready;
  logic [5:0] set_min;
  logic [4:0] set_hour;
  logic       set_err;
  logic       tick_overrun;
`ifdef ALARM_EN
  logic [5:0] alarm_min;
  logic [4:0] alarm_hour;
  logic       alarm_arm;
  logic       alarm;
`endif

  int checks   = 0;
  int failures = 0;

  minute_hour_cascade dut (
    .clk          (clk),
    .rst          (rst),
    .min_tick     (min_tick),
    .minutes      (minutes),
    .hours        (hours),
    .hour_done    (hour_done),
    .day_done     (day_done),
    .set_valid    (set_valid),
    .set_ready    (set_ready),
    .set_min      (set_min),
    .set_hour     (set_hour),
    .set_err      (set_err),
    .tick_overrun (tick_overrun)
`ifdef ALARM_EN
    ,
    .alarm_min    (alarm_min),
    .alarm_hour   (alarm_hour),
    .alarm_arm    (alarm_arm),
    .alarm        (alarm)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick();
    min_tick = 1'b1;
    cyc();
    min_tick = 1'b0;
  endtask

  // Returns at the negedge after the CHECK-cycle clock edge.
  task automatic do_set(input logic [5:0] m, input logic [4:0] h,
                        input logic tick_acc, input logic tick_chk);
    int n;
    n = 0;
    while (set_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (set_ready !== 1'b1) begin
      failures++;
      $display("FAIL set_ready_wait got=%b want=1", set_ready);
    end
    set_valid = 1'b1;
    set_min   = m;
    set_hour  = h;
    min_tick  = tick_acc;
    cyc();
    set_valid = 1'b0;
    min_tick  = tick_chk;
    cyc();
    min_tick  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({minutes, hours, hour_done, day_done, set_err, tick_overrun, set_ready} !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0d:%0d hd=%b dd=%b err=%b ovr=%b rdy=%b want=all zero",
               hours, minutes, hour_done, day_done, set_err, tick_overrun, set_ready);
    end
    rst = 1'b0;
    checks++;
    if (set_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release got=%b want=0", set_ready);
    end
    cyc();
    checks++;
    if (set_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release got=%b want=1", set_ready);
    end
  endtask

  task automatic test_minute_count();
    int hd;
    int dd;
    hd = 0;
    dd = 0;
    for (int i = 1; i <= 61; i++) begin
      tick();
      if (i == 60) begin
        checks++;
        if (hour_done !== 1'b1 || minutes !== 6'd0 || hours !== 5'd1) begin
          failures++;
          $display("FAIL hour_done_at_60 got=%b %0d:%0d want=1 1:0", hour_done, hours, minutes);
        end
      end
      if (hour_done === 1'b1) hd++;
      if (day_done === 1'b1) dd++;
      for (int k = 0; k < 9; k++) begin
        cyc();
        if (hour_done === 1'b1) hd++;
        if (day_done === 1'b1) dd++;
      end
    end
    checks++;
    if (minutes !== 6'd1 || hours !== 5'd1) begin
      failures++;
      $display("FAIL count_time got=%0d:%0d want=1:1", hours, minutes);
    end
    checks++;
    if (hd != 1) begin
      failures++;
      $display("FAIL hour_done_count got=%0d want=1", hd);
    end
    checks++;
    if (dd != 0) begin
      failures++;
      $display("FAIL day_done_count got=%0d want=0", dd);
    end
  endtask

  task automatic test_set_valid();
    do_set(6'd59, 5'd23, 1'b0, 1'b0);
    checks++;
    if (set_err !== 1'b0 || minutes !== 6'd1 || hours !== 5'd1) begin
      failures++;
      $display("FAIL set_apply_cycle got=err%b %0d:%0d want=err0 1:1", set_err, hours, minutes);
    end
    cyc();
    checks++;
    if (minutes !== 6'd59 || hours !== 5'd23 || set_err !== 1'b0) begin
      failures++;
      $display("FAIL set_visible got=%0d:%0d err=%b want=23:59 err=0", hours, minutes, set_err);
    end
    tick();
    checks++;
    if (minutes !== 6'd0 || hours !== 5'd0 || hour_done !== 1'b1 || day_done !== 1'b1) begin
      failures++;
      $display("FAIL day_wrap got=%0d:%0d hd=%b dd=%b want=0:0 hd=1 dd=1",
               hours, minutes, hour_done, day_done);
    end
    cyc();
    checks++;
    if (hour_done !== 1'b0 || day_done !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pulse_width got=hd%b dd%b want=hd0 dd0", hour_done, day_done);
    end
  endtask

  task automatic test_set_range();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) do_set(6'd10, 5'd24, 1'b0, 1'b0);
      else        do_set(6'd60, 5'd5, 1'b0, 1'b0);
      checks++;
      if (set_err !== 1'b1 || minutes !== 6'd0 || hours !== 5'd0) begin
        failures++;
        $display("FAIL range_err_%0d got=err%b %0d:%0d want=err1 0:0", v, set_err, hours, minutes);
      end
      cyc();
      checks++;
      if (set_err !== 1'b0 || set_ready !== 1'b1 || minutes !== 6'd0 || hours !== 5'd0) begin
        failures++;
        $display("FAIL range_after_%0d got=err%b rdy%b %0d:%0d want=err0 rdy1 0:0",
                 v, set_err, set_ready, hours, minutes);
      end
    end
  endtask

  task automatic test_tick_on_accept();
    do_set(6'd20, 5'd10, 1'b1, 1'b0);
    cyc();
    checks++;
    if (minutes !== 6'd20 || hours !== 5'd10) begin
      failures++;
      $display("FAIL pend_apply got=%0d:%0d want=10:20", hours, minutes);
    end
    cyc();
    checks++;
    if (minutes !== 6'd21 || hours !== 5'd10 || tick_overrun !== 1'b0) begin
      failures++;
      $display("FAIL pend_inc got=%0d:%0d ovr=%b want=10:21 ovr=0", hours, minutes, tick_overrun);
    end
  endtask

  task automatic test_overrun();
    do_set(6'd20, 5'd10, 1'b1, 1'b1);
    cyc();
    checks++;
    if (minutes !== 6'd20 || hours !== 5'd10) begin
      failures++;
      $display("FAIL ovr_apply got=%0d:%0d want=10:20", hours, minutes);
    end
    cyc();
    cyc();
    checks++;
    if (minutes !== 6'd21 || hours !== 5'd10 || tick_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_result got=%0d:%0d ovr=%b want=10:21 ovr=1", hours, minutes, tick_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (set_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    set_valid = 1'b1;
    set_min   = 6'd7;
    set_hour  = 5'd7;
    cyc();
    set_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (minutes !== 6'd0 || hours !== 5'd0 || set_ready !== 1'b0 || tick_overrun !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%0d:%0d rdy=%b ovr=%b want=0:0 rdy=0 ovr=0",
               hours, minutes, set_ready, tick_overrun);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (set_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_midreset got=%b want=1", set_ready);
    end
    cyc();
    cyc();
    checks++;
    if (minutes !== 6'd0 || hours !== 5'd0) begin
      failures++;
      $display("FAIL no_write_after_reset got=%0d:%0d want=0:0", hours, minutes);
    end
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    alarm_arm  = 1'b1;
    alarm_min  = 6'd2;
    alarm_hour = 5'd0;
    tick();
    checks++;
    if (alarm !== 1'b0 || minutes !== 6'd1) begin
      failures++;
      $display("FAIL alarm_early got=%b min=%0d want=0 min=1", alarm, minutes);
    end
    tick();
    checks++;
    if (alarm !== 1'b1 || minutes !== 6'd2 || hours !== 5'd0) begin
      failures++;
      $display("FAIL alarm_fire got=%b %0d:%0d want=1 0:2", alarm, hours, minutes);
    end
    cyc();
    checks++;
    if (alarm !== 1'b0) begin
      failures++;
      $display("FAIL alarm_width got=%b want=0", alarm);
    end
    do_set(6'd2, 5'd0, 1'b0, 1'b0);
    cyc();
    checks++;
    if (alarm !== 1'b0 || minutes !== 6'd2) begin
      failures++;
      $display("FAIL alarm_on_set got=%b min=%0d want=0 min=2", alarm, minutes);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    min_tick  = 1'b0;
    set_valid = 1'b0;
    set_min   = 6'd0;
    set_hour  = 5'd0;
`ifdef ALARM_EN
    alarm_arm  = 1'b0;
    alarm_min  = 6'd0;
    alarm_hour = 5'd0;
`endif
    cyc();
    test_reset();
    test_minute_count();
    test_set_valid();
    test_set_range();
    test_tick_on_accept();
    test_overrun();
    test_reset_mid();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minute_hour_cascade.md
Name: minute_hour_cascade

Overview:
Downstream stage of the seconds counter. Consumes its one-cycle `counter_done` pulse (one per elapsed minute) as `min_tick` and maintains minutes/hours time-of-day registers. Provides a valid/ready set interface with range checking, and emits hour/day rollover pulses for later display and alarm logic.

Parameters:
MIN_MOD, 60, minutes modulus; minutes count 0..MIN_MOD-1
HOUR_MOD, 24, hours modulus; hours count 0..HOUR_MOD-1
MIN_W, 6, minutes width; must satisfy 2**MIN_W >= MIN_MOD
HOUR_W, 5, hours width; must satisfy 2**HOUR_W >= HOUR_MOD

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
min_tick  in  1  one-cycle pulse from upstream counter_done
minutes  out  MIN_W  current minutes, registered
hours  out  HOUR_W  current hours, registered
hour_done  out  1  one-cycle pulse when minutes wrap MIN_MOD-1 -> 0
day_done  out  1  one-cycle pulse when time wraps (HOUR_MOD-1):(MIN_MOD-1) -> 0:0
set_valid  in  1  set request valid
set_ready  out  1  block can accept a set
set_min  in  MIN_W  requested minutes
set_hour  in  HOUR_W  requested hours
set_err  out  1  one-cycle pulse: accepted request was out of range and discarded
tick_overrun  out  1  sticky: a min_tick was dropped; cleared only by rst

Behaviour:
- Reset (async, rst=1): minutes=0, hours=0, hour_done=0, day_done=0, set_err=0, tick_overrun=0, set_ready=0, state=RUN, pending=0. set_ready rises one cycle after rst deasserts.
- FSM states: RUN, CHECK, APPLY. set_ready=1 only in RUN (registered).
- RUN:
  - A tick (min_tick=1 or pending=1) increments time at that clock edge, so the new value is visible 1 cycle after the pulse. pending clears.
  - minutes+1 wraps to 0 at MIN_MOD and asserts hour_done the next cycle.
  - On a minute wrap, hours+1 wraps to 0 at HOUR_MOD and asserts day_done in the same cycle as hour_done.
  - Arithmetic is compare-to-modulus, never width overflow; values at or above the modulus never appear.
- Set accept: set_valid && set_ready in RUN. Capture set_min/set_hour into staging registers, go to CHECK. A min_tick coincident with accept does not modify time; it sets pending.
- CHECK:
  - If staged min >= MIN_MOD or staged hour >= HOUR_MOD: pulse set_err, keep time, go to RUN.
  - Otherwise go to APPLY.
- APPLY: write staged values to minutes/hours, go to RUN. Total accept-to-visible latency is 2 cycles.
- Ticks in CHECK/APPLY set pending. pending is applied in the first RUN cycle after return, so the set value plus one minute is visible 1 cycle later.
- pending saturates at 1. A tick arriving while pending=1 is dropped and sets tick_overrun.
- hour_done/day_done pulses generated from a pending tick behave identically to direct ticks.
- set_valid while set_ready=0 is ignored; the requester holds until ready.
- rst mid-CHECK/APPLY discards staged values; no partial write.

Optional Feature:
ALARM_EN
- Defined: adds ports alarm_min (in, MIN_W), alarm_hour (in, HOUR_W), alarm_arm (in, 1) and alarm (out, 1).
  - alarm pulses for one cycle, coincident with the updated time, when alarm_arm=1 and a tick-driven increment makes {hours,minutes} equal {alarm_hour,alarm_min}.
  - Set-driven writes never fire alarm.
  - alarm resets to 0.
- Undefined: these ports and all alarm logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package mhc_pkg: state enum typedef (RUN, CHECK, APPLY), default MIN_MOD/HOUR_MOD localparams, MIN_W/HOUR_W defaults.
- Sub-module wrap_inc #(MOD, W):
  - Combinational: value in, inc in; next value and wrap flag out.
  - Instantiated twice (minutes, hours); the hours instance has inc tied to the minutes wrap flag.

Test Plan:
- Reset, then 61 min_tick pulses spaced 10 cycles -> minutes=1, hours=1; exactly one hour_done pulse, 1 cycle after the 60th tick; day_done never.
- Set 23:59 (valid), then one min_tick -> set_err never; 2 cycles after accept time=23:59; after the tick time=0:0 with hour_done and day_done high for one cycle.
- Set 24:10 -> set_err pulses 1 cycle after CHECK entry, time unchanged, set_ready back to 1 next cycle; set 5:60 -> same.
- Set 10:20 with min_tick coincident with accept -> after APPLY shows 10:20, next cycle 10:21; no overrun. Repeat with ticks on the accept cycle and the CHECK cycle -> 10:21 only, tick_overrun=1.
- Assert rst during CHECK of a valid set 7:07 -> outputs 0 immediately (async), no write after release, set_ready=1 one cycle after release.
- ALARM_EN: arm 0:02, tick twice from 0:00 -> alarm pulses once, coincident with 0:02; a set to 0:02 -> no alarm.
